// File: rtl/sba_pkg.sv
// Shared SBA bus constants and helpers used by the SDRAM decode and bridge.
// The SDRAM window is 32 MB, so the controller sees a 25-bit byte address.
package sba_pkg;

    localparam int SBA_DW  = 32;
    localparam int SBA_WEW = 4;

    localparam int          SDRAM_AW   = 25;
    localparam logic [31:0] SDRAM_BASE = 32'h4000_0000;
    localparam logic [31:0] SDRAM_SIZE = 32'h0200_0000;

    function automatic logic sba_is_write(input logic [SBA_WEW-1:0] we);
        return |we;
    endfunction

    function automatic logic sba_in_sdram(input logic [31:0] addr);
        return (addr >= SDRAM_BASE) && (addr < (SDRAM_BASE + SDRAM_SIZE));
    endfunction

endpackage

// File: rtl/sba_wbuf.sv
// One-entry posted write buffer: captures an SBA write on load and holds it
// until the bridge has handed it to the controller and the command completed.
module sba_wbuf
    import sba_pkg::*;
#(
    parameter int AW = 25,
    parameter int DW = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [AW-1:0]      i_addr,
    input  logic [DW-1:0]      i_data,
    input  logic [SBA_WEW-1:0] i_mask,
    output logic               o_valid,
    output logic [AW-1:0]      o_addr,
    output logic [DW-1:0]      o_data,
    output logic [SBA_WEW-1:0] o_mask
);

    logic               valid_q, valid_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      data_q, data_d;
    logic [SBA_WEW-1:0] mask_q, mask_d;

    // load only happens while empty and clear only while full, so they never collide
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        if (i_clear) begin
            valid_d = 1'b0;
        end else if (i_load) begin
            valid_d = 1'b1;
            addr_d  = i_addr;
            data_d  = i_data;
            mask_d  = i_mask;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    assign o_valid = valid_q;
    assign o_addr  = addr_q;
    assign o_data  = data_q;
    assign o_mask  = mask_q;

endmodule

// File: rtl/sdram_bridge.sv
// SBA-to-SDRAM-controller bridge: posts writes through a one-entry buffer with
// an early ack, and issues reads only once the buffer has drained.
//
// state | meaning
// IDLE  | drain a buffered write, or issue a read, when the controller is free
// WR    | write command accepted, waiting for busy to drop
// RD    | read command accepted, waiting for busy to drop to capture data
// ACK   | read data registered, ack pulse to the SBA master
module sdram_bridge
    import sba_pkg::*;
#(
    parameter int AW = 25,
    parameter int DW = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_stb,
    input  logic [SBA_WEW-1:0] i_we,
    input  logic [AW-1:0]      i_addr,
    input  logic [DW-1:0]      i_dat_w,
    output logic [DW-1:0]      o_dat_r,
    output logic               o_ack,
    output logic               o_sd_rd,
    output logic [SBA_WEW-1:0] o_sd_wmask,
    output logic [AW-1:0]      o_sd_addr,
    output logic [DW-1:0]      o_sd_din,
    input  logic [DW-1:0]      i_sd_dout,
    input  logic               i_sd_busy,
    output logic               o_idle
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;

    logic [1:0]   state_q, state_d;
    logic         run_q;
    logic         wack_q, wack_d;
    logic [DW-1:0] dat_r_q, dat_r_d;

    logic               wb_valid;
    logic [AW-1:0]      wb_addr;
    logic [DW-1:0]      wb_data;
    logic [SBA_WEW-1:0] wb_mask;

    logic wr_accept;
    logic drain;
    logic rd_issue;
    logic wb_clear;

    // run_q keeps every command and accept quiet while reset is held, even if
    // the master is still presenting a strobe from before the reset
    assign wr_accept = run_q & i_stb & sba_is_write(i_we) & ~wb_valid & ~o_ack;
    assign drain     = run_q & (state_q == ST_IDLE) & wb_valid & ~i_sd_busy;
    assign rd_issue  = run_q & (state_q == ST_IDLE) & i_stb & ~sba_is_write(i_we)
                     & ~wb_valid & ~o_ack & ~i_sd_busy;
    assign wb_clear  = (state_q == ST_WR) & ~i_sd_busy;

    sba_wbuf #(
        .AW (AW),
        .DW (DW)
    ) u_wbuf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (wr_accept),
        .i_clear (wb_clear),
        .i_addr  (i_addr),
        .i_data  (i_dat_w),
        .i_mask  (i_we),
        .o_valid (wb_valid),
        .o_addr  (wb_addr),
        .o_data  (wb_data),
        .o_mask  (wb_mask)
    );

    always_comb begin
        state_d = state_q;
        dat_r_d = dat_r_q;
        wack_d  = wr_accept;
        case (state_q)
            ST_IDLE: begin
                if (drain) begin
                    state_d = ST_WR;
                end else if (rd_issue) begin
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                if (!i_sd_busy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (!i_sd_busy) begin
                    dat_r_d = i_sd_dout;
                    state_d = ST_ACK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            wack_q  <= 1'b0;
            dat_r_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            wack_q  <= wack_d;
            dat_r_q <= dat_r_d;
        end
    end

    assign o_ack      = wack_q | (state_q == ST_ACK);
    assign o_dat_r    = dat_r_q;
    assign o_sd_rd    = rd_issue;
    assign o_sd_wmask = drain ? wb_mask : '0;
    assign o_sd_din   = drain ? wb_data : '0;
    assign o_sd_addr  = drain ? wb_addr : (rd_issue ? i_addr : '0);
    assign o_idle     = ~wb_valid & (state_q == ST_IDLE);

endmodule
